// File: rtl/sample_buffer.sv
// Frame buffer between an upstream sample stream and the max/min scanner.
// Fills DEPTH entries, freezes for combinational scanner reads, releases on a scan_done rising edge.
module sample_buffer #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 1024,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              nRST,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  input  logic [ADDR_W:0]   rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              scan_done,
  output logic              buf_full,
  output logic [ADDR_W:0]   fill_count,
  output logic [7:0]        frame_cnt
);

  typedef enum logic {
    FILL  = 1'b0,
    SERVE = 1'b1
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [ADDR_W-1:0] wr_ptr;
  logic              scan_done_q;
  logic              accept;
  logic              last_write;
  logic              release_edge;
  logic [DATA_W-1:0] mem [DEPTH];
  logic              unused_rd_msb;

  // Stream handshake: a sample transfers on a posedge where in_valid && in_ready;
  // in_ready depends only on state, never on in_valid, and in_data is held by the source while stalled.
  assign accept       = in_valid && (state == FILL);
  assign last_write   = accept && (wr_ptr == ADDR_W'(DEPTH - 1));
  assign release_edge = (state == SERVE) && scan_done && !scan_done_q;

  assign in_ready = (state == FILL);
  assign buf_full = (state == SERVE);

  always_comb begin
    state_next = state;
    case (state)
      FILL:    if (last_write)   state_next = SERVE;
      SERVE:   if (release_edge) state_next = FILL;
      default: state_next = FILL;
    endcase
  end

  always_ff @(posedge clk or posedge nRST) begin
    if (nRST) begin
      state       <= FILL;
      wr_ptr      <= '0;
      fill_count  <= '0;
      frame_cnt   <= '0;
      scan_done_q <= 1'b0;
    end else begin
      state       <= state_next;
      scan_done_q <= scan_done;
      if (accept) begin
        wr_ptr     <= wr_ptr + ADDR_W'(1);
        fill_count <= fill_count + (ADDR_W + 1)'(1);
      end else if (release_edge) begin
        fill_count <= '0;
        frame_cnt  <= frame_cnt + 8'd1;
      end
    end
  end

  // Storage has no reset; contents persist across frames and resets.
  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= in_data;
  end

  // Address DEPTH (MSB set) aliases entry 0, so the MSB is dropped.
  assign rd_data       = mem[rd_addr[ADDR_W-1:0]];
  assign unused_rd_msb = rd_addr[ADDR_W];

endmodule

// File: tb/tb_sample_buffer.sv
// Self-checking bench for sample_buffer: per-cycle comparison against a frame-level model,
// a table of serve-phase reads, and hand-written release/reset sequences.
module tb_sample_buffer;

  localparam int DW = 8;
  localparam int DEPTH = 1024;
  localparam int AW = 10;

  logic          clk;
  logic          nRST;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW:0]   rd_addr;
  logic [DW-1:0] rd_data;
  logic          scan_done;
  logic          buf_full;
  logic [AW:0]   fill_count;
  logic [7:0]    frame_cnt;

  sample_buffer #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW)) dut (
    .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_addr(rd_addr), .rd_data(rd_data), .scan_done(scan_done), .buf_full(buf_full),
    .fill_count(fill_count), .frame_cnt(frame_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // frame-level reference model
  logic [DW-1:0] ref_mem [DEPTH];
  int            ref_count;
  bit            ref_full;
  int            ref_frame;
  bit            ref_prev_done;
  logic [DW-1:0] frame_data [DEPTH];

  typedef struct {
    logic [AW:0]   addr;
    logic          vld;
    logic [DW-1:0] dat;
    logic [DW-1:0] exp_data;
  } serve_vec_t;
  serve_vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    ref_count = 0;
    ref_full = 0;
    ref_frame = 0;
    ref_prev_done = 0;
  endtask

  // Entered and left at posedge+1: drive, compare pre-edge outputs, then advance the model across the edge.
  task automatic step(input logic v, input logic [DW-1:0] d, input logic [AW:0] a, input logic dn);
    in_valid = v;
    in_data = d;
    rd_addr = a;
    scan_done = dn;
    #1;
    chk("in_ready", 32'(in_ready), 32'(!ref_full));
    chk("buf_full", 32'(buf_full), 32'(ref_full));
    chk("fill_count", 32'(fill_count), 32'(ref_count));
    chk("frame_cnt", 32'(frame_cnt), 32'(ref_frame % 256));
    if (ref_full) chk("rd_data", 32'(rd_data), 32'(ref_mem[int'(a) % DEPTH]));
    @(posedge clk);
    if (!ref_full && v) begin
      ref_mem[ref_count] = d;
      ref_count++;
      if (ref_count == DEPTH) ref_full = 1;
    end else if (ref_full && dn && !ref_prev_done) begin
      ref_full = 0;
      ref_count = 0;
      ref_frame++;
    end
    ref_prev_done = dn;
    #1;
  endtask

  // mode 0: valid held, 1: valid toggles starting high, 2: random valid
  task automatic fill(input int mode, input int target, input logic dn);
    int n;
    logic v;
    n = 0;
    while (ref_count < target && !ref_full && n < 8000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (n % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      step(v, frame_data[ref_count], 11'($urandom_range(0, 2047)), dn);
      n++;
    end
    chk("fill_reached", 32'(fill_count), 32'(target));
  endtask

  task automatic read_all();
    for (int a = 0; a < DEPTH; a++) step(1'b0, 8'h00, 11'(a), 1'b0);
  endtask

  task automatic release_frame();
    step(1'b0, 8'h00, 11'd0, 1'b1);
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    chk("rel_buf_full", 32'(buf_full), 32'd0);
    chk("rel_fill_count", 32'(fill_count), 32'd0);
    step(1'b0, 8'h00, 11'd0, 1'b0);
  endtask

  initial begin
    int p3;
    int p250;
    int mx;
    int mn;
    nRST = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    rd_addr = '0;
    scan_done = 1'b0;
    model_reset();

    tbl[0] = '{11'd0,    1'b0, 8'h00, 8'd0};
    tbl[1] = '{11'd5,    1'b0, 8'h00, 8'd5};
    tbl[2] = '{11'd1023, 1'b0, 8'h00, 8'd255};
    tbl[3] = '{11'd1024, 1'b0, 8'h00, 8'd0};
    tbl[4] = '{11'd5,    1'b1, 8'hAA, 8'd5};
    tbl[5] = '{11'd0,    1'b1, 8'hAA, 8'd0};
    tbl[6] = '{11'd1023, 1'b1, 8'hAA, 8'd255};
    tbl[7] = '{11'd1536, 1'b1, 8'hAA, 8'd0};

    // reset values
    #12;
    chk("rst_fill_count", 32'(fill_count), 32'd0);
    chk("rst_buf_full", 32'(buf_full), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    #6 nRST = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;

    // frame 1: ramp data, valid held high
    for (int k = 0; k < DEPTH; k++) frame_data[k] = 8'(k % 256);
    fill(0, DEPTH, 1'b0);
    chk("full_after_ramp", 32'(buf_full), 32'd1);
    chk("ready_after_ramp", 32'(in_ready), 32'd0);
    read_all();

    // serve-phase read table; writes offered here must be ignored
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].vld, tbl[i].dat, tbl[i].addr, 1'b0);
      chk("tbl_rd_data", 32'(rd_data), 32'(tbl[i].exp_data));
      chk("tbl_buf_full", 32'(buf_full), 32'd1);
    end
    release_frame();
    chk("frame_after_1", 32'(frame_cnt), 32'd1);

    // frame 2: valid toggling, random data
    for (int k = 0; k < DEPTH; k++) frame_data[k] = 8'($urandom_range(0, 255));
    fill(1, DEPTH, 1'b0);
    read_all();
    release_frame();

    // frame 3: scanner emulation over random 10..200 data with one 3 and one 250
    p3 = $urandom_range(0, DEPTH - 1);
    p250 = (p3 + 1 + $urandom_range(0, DEPTH - 2)) % DEPTH;
    for (int k = 0; k < DEPTH; k++) frame_data[k] = 8'($urandom_range(10, 200));
    frame_data[p3] = 8'd3;
    frame_data[p250] = 8'd250;
    fill(2, DEPTH, 1'b0);
    mx = 0;
    mn = 255;
    for (int a = 0; a < DEPTH; a++) begin
      step(1'b0, 8'h00, 11'(a), 1'b0);
      if (int'(rd_data) > mx) mx = int'(rd_data);
      if (int'(rd_data) < mn) mn = int'(rd_data);
    end
    chk("scan_max", 32'(mx), 32'd250);
    chk("scan_min", 32'(mn), 32'd3);
    release_frame();
    chk("frame_after_3", 32'(frame_cnt), 32'd3);

    // frame 4: scan_done held high across the fill must not release
    for (int k = 0; k < DEPTH; k++) frame_data[k] = 8'($urandom_range(0, 255));
    step(1'b0, 8'h00, 11'd0, 1'b1);
    fill(0, DEPTH, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'h55, 11'($urandom_range(0, 2047)), 1'b1);
    chk("held_done_full", 32'(buf_full), 32'd1);
    step(1'b0, 8'h00, 11'd0, 1'b0);
    release_frame();
    chk("frame_after_4", 32'(frame_cnt), 32'd4);

    // reset after 500 accepts, then a full frame must start at entry 0
    for (int k = 0; k < DEPTH; k++) frame_data[k] = 8'((k * 7 + 3) % 256);
    fill(0, 500, 1'b0);
    in_valid = 1'b0;
    #2 nRST = 1'b1;
    #1;
    chk("midrst_fill_count", 32'(fill_count), 32'd0);
    chk("midrst_buf_full", 32'(buf_full), 32'd0);
    chk("midrst_frame_cnt", 32'(frame_cnt), 32'd0);
    model_reset();
    #1 nRST = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    for (int k = 0; k < DEPTH; k++) frame_data[k] = 8'($urandom_range(0, 255));
    fill(2, DEPTH, 1'b0);
    read_all();
    release_frame();
    chk("frame_after_rst", 32'(frame_cnt), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
